// File: rtl/vco_freq_pkg.sv
// Shared types and constants for the VCO frequency counter.
package vco_freq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned ARM_CYCLES   = 2;
    localparam int unsigned ARM_CNT_W    = 2;
    localparam int unsigned GATE_EXP_MIN = 4;
    localparam int unsigned GATE_TMR_W   = 16;
    localparam int unsigned GATE_EXP_W   = 4;

    // Short windows make the +/-1 edge quantisation dominate, so floor the exponent.
    function automatic logic [GATE_EXP_W-1:0] clamp_gate_exp(input logic [GATE_EXP_W-1:0] g);
        return (g < GATE_EXP_W'(GATE_EXP_MIN)) ? GATE_EXP_W'(GATE_EXP_MIN) : g;
    endfunction

    // Timer preload so the window lasts exactly 2^g cycles (counts down to zero inclusive).
    function automatic logic [GATE_TMR_W-1:0] gate_preload(input logic [GATE_EXP_W-1:0] g);
        logic [31:0] full;
        full = (32'd1 << g) - 32'd1;
        return full[GATE_TMR_W-1:0];
    endfunction

endpackage

// File: rtl/vco_edge_sync.sv
// N-stage synchroniser for one raw VCO input followed by a rising-edge detector.
module vco_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/vco_freq_counter.sv
// Gated edge counter for the dual ring-oscillator VCO; result is read out a byte at a time.
// Optional build macro VCO_FREQ_CONTINUOUS_EN: re-arm automatically while start stays high.
module vco_freq_counter
    import vco_freq_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       vco_in,
    input  logic             start,
    input  logic             sel,
    input  logic [3:0]       gate_exp,
    input  logic             byte_sel,
    output logic [CNT_W-1:0] result,
    output logic [7:0]       out_byte,
    output logic             valid,
    output logic             busy,
    output logic             ovf
);

    localparam int unsigned EXT_W = (CNT_W > 16) ? CNT_W : 16;

    logic [1:0] rise_c;

    for (genvar i = 0; i < 2; i++) begin : g_sync
        vco_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (vco_in[i]),
            .rise_c (rise_c[i])
        );
    end

    state_t                  state_q, state_d;
    logic                    start_q;
    logic                    sel_q;
    logic [GATE_EXP_W-1:0]   gexp_q;
    logic [ARM_CNT_W-1:0]    arm_cnt_q;
    logic [GATE_TMR_W-1:0]   tmr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_acc_q;

    logic                    start_rise_c;
    logic                    arm_c, gate_c, done_c, idle_c;
    logic                    cnt_en_c;
    logic [CNT_W-1:0]        cnt_nxt_c;
    logic                    ovf_nxt_c;

    assign start_rise_c = start & ~start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arm_c   = 1'b0;
        gate_c  = 1'b0;
        done_c  = 1'b0;
        idle_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise_c) begin
                    state_d = ARM;
                    arm_c   = 1'b1;
                end
            end
            ARM: begin
                if (arm_cnt_q == ARM_CNT_W'(ARM_CYCLES - 1)) begin
                    state_d = GATE;
                    gate_c  = 1'b1;
                end
            end
            GATE: begin
                if (tmr_q == '0) begin
                    state_d = DONE;
                    done_c  = 1'b1;
                end
            end
            DONE: begin
`ifdef VCO_FREQ_CONTINUOUS_EN
                if (start) begin
                    state_d = ARM;
                    arm_c   = 1'b1;
                end else begin
                    state_d = IDLE;
                    idle_c  = 1'b1;
                end
`else
                if (start_rise_c) begin
                    state_d = ARM;
                    arm_c   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count; the final GATE cycle's edge is folded into the latched result.
    always_comb begin
        cnt_en_c  = (state_q == GATE) && rise_c[sel_q];
        cnt_nxt_c = cnt_q;
        ovf_nxt_c = ovf_acc_q;
        if (cnt_en_c) begin
            if (cnt_q == {CNT_W{1'b1}}) ovf_nxt_c = 1'b1;
            else                        cnt_nxt_c = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            sel_q     <= 1'b0;
            gexp_q    <= GATE_EXP_W'(GATE_EXP_MIN);
            arm_cnt_q <= '0;
            tmr_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            result    <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            start_q   <= start;
            cnt_q     <= cnt_nxt_c;
            ovf_acc_q <= ovf_nxt_c;
            busy      <= (state_d == ARM) || (state_d == GATE);
            if (state_q == ARM)  arm_cnt_q <= arm_cnt_q + ARM_CNT_W'(1);
            if (state_q == GATE) tmr_q     <= tmr_q - GATE_TMR_W'(1);
            if (arm_c) begin
                sel_q     <= sel;
                gexp_q    <= clamp_gate_exp(gate_exp);
                arm_cnt_q <= '0;
                cnt_q     <= '0;
                ovf_acc_q <= 1'b0;
                if (start_rise_c) begin
                    valid <= 1'b0;
                    ovf   <= 1'b0;
                end
            end
            if (gate_c) tmr_q <= gate_preload(gexp_q);
            if (done_c) begin
                result <= cnt_nxt_c;
                ovf    <= ovf_nxt_c;
                valid  <= 1'b1;
            end
            if (idle_c) valid <= 1'b0;
        end
    end

    // Byte readout; narrow builds read zeros in the high byte.
    logic [EXT_W-1:0] res_ext_c;

    always_comb begin
        res_ext_c = EXT_W'(result);
        out_byte  = byte_sel ? res_ext_c[15:8] : res_ext_c[7:0];
    end

endmodule
